// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types: word, cacheline, arbiter state, grant choice.
// Pure declarations; no timing or flow control of its own.
package cache_arbiter_pkg;

    localparam int LC3B_WORD_W = 16;
    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ICACHE,
        ARB_DCACHE
    } lc3b_arb_state;

    // On a tie the requester that did not win last time gets the port.
    function automatic lc3b_arb_state arb_pick(input logic i_req,
                                               input logic d_req,
                                               input logic last_d);
        lc3b_arb_state pick;
        pick = ARB_IDLE;
        if (i_req && d_req)
            pick = last_d ? ARB_ICACHE : ARB_DCACHE;
        else if (i_req)
            pick = ARB_ICACHE;
        else if (d_req)
            pick = ARB_DCACHE;
        return pick;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I-cache and D-cache.
// Grant visible one cycle after request; resp is combinational from pmem_resp; losers hold until IDLE.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              icache_read,
    input  logic [15:0]       icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [15:0]       dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    lc3b_arb_state state;
    lc3b_arb_state state_next;
    logic          last_d;
    logic          i_req;
    logic          d_req;

    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARB_IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && state_next != ARB_IDLE)
                last_d <= (state_next == ARB_DCACHE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   state_next = arb_pick(i_req, d_req, last_d);
            ARB_ICACHE,
            ARB_DCACHE: if (pmem_resp) state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    // Commands decode from state only, except the read/write choice inside a D grant.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        case (state)
            ARB_ICACHE: begin
                pmem_read    = 1'b1;
                pmem_address = icache_address;
                icache_resp  = pmem_resp;
            end
            ARB_DCACHE: begin
                pmem_read    = dcache_read;
                pmem_write   = dcache_write;
                pmem_address = dcache_address;
                dcache_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    // Data buses are plain pass-throughs, forced quiet while reset is held.
    assign pmem_wdata   = reset ? '0 : dcache_wdata;
    assign icache_rdata = reset ? '0 : pmem_rdata;
    assign dcache_rdata = reset ? '0 : pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction cache (fetch stage) and the data cache (memory stage) of the pipelined LC-3b. It grants one outstanding cacheline transaction at a time, steers address and data, and routes the memory response back to the granted requester. The arbiter uses a round-robin tie-break, so a fetch stream cannot starve loads and stores, and a burst of `in_mem` operations cannot starve fetch.

## Interface

**Parameters**
- `LINE_W`, default 128: cacheline width in bits.

**Ports**
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `icache_read` in 1: instruction-cache line-fill request.
- `icache_address` in 16: line address (`lc3b_word`).
- `icache_resp` out 1: one-cycle completion pulse to the instruction cache.
- `icache_rdata` out LINE_W: fill data.
- `dcache_read` in 1: data-cache line-fill request.
- `dcache_write` in 1: data-cache writeback request.
- `dcache_address` in 16: line address.
- `dcache_wdata` in LINE_W: writeback data.
- `dcache_resp` out 1: one-cycle completion pulse to the data cache.
- `dcache_rdata` out LINE_W: fill data.
- `pmem_read` out 1, `pmem_write` out 1: memory commands.
- `pmem_address` out 16, `pmem_wdata` out LINE_W: to memory.
- `pmem_rdata` in LINE_W, `pmem_resp` in 1: from memory.

## Operation

**State machine.** States are `ARB_IDLE`, `ARB_ICACHE`, `ARB_DCACHE`, plus a 1-bit register `last_d`, which is 1 if the last granted requester was the data cache.

**Transitions from `ARB_IDLE`:**
- i_req only → `ARB_ICACHE`.
- d_req only → `ARB_DCACHE`.
- Both → `ARB_ICACHE` if `last_d` = 1, else `ARB_DCACHE`.
- Neither → stay in `ARB_IDLE`.
- Here `i_req = icache_read` and `d_req = dcache_read | dcache_write`.

**Grant states:**
- `ARB_ICACHE`/`ARB_DCACHE` → `ARB_IDLE` on `pmem_resp`; otherwise hold.
- `last_d` updates on entry into a grant state.

**Output decode (Moore commands):**
- `ARB_ICACHE`: `pmem_read`=1, `pmem_address`=`icache_address`.
- `ARB_DCACHE`: `pmem_read`=`dcache_read`, `pmem_write`=`dcache_write`, `pmem_address`=`dcache_address`.
- `pmem_wdata`=`dcache_wdata` in all states.
- `ARB_IDLE`: `pmem_read`=`pmem_write`=0, `pmem_address`=0.

**Responses:**
- `icache_resp` = `pmem_resp` & (state==`ARB_ICACHE`); `dcache_resp` likewise for `ARB_DCACHE`.
- `icache_rdata` = `dcache_rdata` = `pmem_rdata` (broadcast); only the resp pulse qualifies the data.

**Requester contract:**
- A requester holds its request and address stable until its resp pulse, and deasserts the request in the cycle after that pulse.
- `dcache_read` and `dcache_write` together is illegal. If it occurs, the arbiter passes both through unchanged and the bench flags it with an assertion.
- A `pmem_resp` arriving in `ARB_IDLE` is ignored: no resp is generated and the state is unchanged.

**Reset.**
- State → `ARB_IDLE`, `last_d` → 0; the first conflict after reset therefore goes to the data cache.
- All outputs go to 0 immediately, including when reset is asserted mid-transaction; the aborted transaction is not resumed.

## Timing

- Request sampled in `ARB_IDLE` at edge N → command visible at N+1.
- Memory `resp` in cycle M → requester resp in the same cycle M (combinational) → `ARB_IDLE` at M+1.
- The earliest next grant is at M+2, so there is one idle bubble between transactions.
- Minimum transaction (memory responds in the first grant cycle) occupies 2 cycles from request to resp.
- A request arriving while the other requester is granted waits until `ARB_IDLE`, then wins because of the round-robin.
- No combinational path from requester inputs to `pmem_read`/`pmem_write`, except `dcache_read`/`dcache_write` selection inside `ARB_DCACHE`.

## Structure

- Add to `lc3b_types`:
  - `typedef logic [127:0] lc3b_cacheline`.
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE} lc3b_arb_state`.
- Single module with no sub-modules: a state register plus `last_d`, a next-state `always_comb`, and an output `always_comb`.
- Instantiated in the CPU top between the two caches and the physical memory.

## Test plan

1. **Reset.** `reset`=1 while `icache_read`=1 → all outputs 0; release reset → `pmem_read`=1, `pmem_address`=`icache_address` (0x1230) one cycle later.
2. **Conflict after reset.** `icache_read`=1 and `dcache_read`=1 in the same cycle, memory latency 3 → data cache served first; `dcache_resp` pulses once; icache granted 2 cycles after `dcache_resp` with its address.
3. **Round-robin.** d_req held continuously for 3 transactions while i_req is also held → grants alternate D, I, D; no requester waits more than one transaction.
4. **Writeback.** `dcache_write`=1, address 0x4440, wdata 0xDEAD…BEEF → `pmem_write`=1 with matching address and data; `icache_resp` stays 0 throughout.
5. **Reset mid-grant.** `reset` pulsed during `ARB_DCACHE` before `pmem_resp` → `pmem_read`=0 immediately; a late `pmem_resp` produces no resp on either side.
6. **Stray response.** `pmem_resp`=1 while in `ARB_IDLE` → both resp outputs remain 0 and the state is unchanged.
